load_store_unit: RTL and testbench

//   Initiator side of the data-memory interface: takes one load/store per request from the
//   MEM pipeline stage and drives word-aligned, byte-strobed requests to the data cache.

---
 rtl/load_store_unit_pkg.sv | 29 ++
 rtl/load_store_unit_align.sv | 61 ++++++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states
// and the data-cache base offset.
package load_store_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] DATA_CACHE_OFFSET = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BEAT0,
        ST_BEAT1,
        ST_DONE,
        ST_ERR
    } lsu_state_e;

    // Stores have no unsigned variants, so any code with bit 2 set is illegal for them.
    function automatic logic f3_illegal(input logic is_store, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (is_store && f3[2]);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte-mask generation, store data placement over two
// words, and load extraction with sign/zero extension.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_val,
    input  logic [63:0] rdata,
    output logic [7:0]  lane_mask,
    output logic        crosses,
    output logic [63:0] wdata,
    output logic [31:0] load_val
);

    logic [3:0]         size_mask;
    logic [63:0]        shifted_store;
    logic [31:0]        rshift;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] byte_ext;
    logic signed [31:0] half_ext;

    always_comb begin
        case (funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign lane_mask     = {4'b0000, size_mask} << offset;
    assign crosses       = |lane_mask[7:4];
    assign shifted_store = {32'h0, store_val} << {offset, 3'b000};

    // Lanes outside the access are forced to zero so SB/SH never leak upper store bits.
    always_comb begin
        wdata = '0;
        for (int i = 0; i < 8; i++) begin
            if (lane_mask[i]) wdata[8*i +: 8] = shifted_store[8*i +: 8];
        end
    end

    assign rshift   = 32'(rdata >> {offset, 3'b000});
    assign byte_s   = rshift[7:0];
    assign half_s   = rshift[15:0];
    assign byte_ext = byte_s;
    assign half_ext = half_s;

    always_comb begin
        case (funct3)
            F3_LB:   load_val = byte_ext;
            F3_LH:   load_val = half_ext;
            F3_LW:   load_val = rshift;
            F3_LBU:  load_val = {24'h0, rshift[7:0]};
            F3_LHU:  load_val = {16'h0, rshift[15:0]};
            default: load_val = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one RV32I load/store per request, split into one or two
// word-aligned, byte-strobed beats with hold-until-ack handshaking.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] MEM_OFFSET = ADDR_W'(DATA_CACHE_OFFSET)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_is_store,
    input  logic [2:0]        i_funct3,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [31:0]       i_store_val,
    output logic              o_done,
    output logic [31:0]       o_load_val,
    output logic              o_err,
    output logic              o_mem_req,
    input  logic              i_mem_ack,
    output logic              o_mem_op_type,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [3:0]        o_mem_strobe,
    output logic [31:0]       o_mem_val,
    input  logic [31:0]       i_mem_val
);

    lsu_state_e        state, state_next;
    logic              accept;
    logic              is_store_p0;
    logic [2:0]        funct3_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic [31:0]       store_val_p0;
    logic [31:0]       rdata0_p1;
    logic [31:0]       rdata1_p1;
    logic [ADDR_W-1:0] beat0_addr;
    logic [7:0]        lane_mask;
    logic              crosses;
    logic [63:0]       wdata;
    logic [31:0]       load_ext;

    assign accept     = (state == ST_IDLE) && i_valid;
    assign beat0_addr = (addr_p0 - MEM_OFFSET) & ~ADDR_W'(3);

    load_store_unit_align u_align (
        .funct3    (funct3_p0),
        .offset    (addr_p0[1:0]),
        .store_val (store_val_p0),
        .rdata     ({rdata1_p1, rdata0_p1}),
        .lane_mask (lane_mask),
        .crosses   (crosses),
        .wdata     (wdata),
        .load_val  (load_ext)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Request latch (stage p0) and read-word capture (stage p1); outputs are gated by
    // state, so these need no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            is_store_p0  <= i_is_store;
            funct3_p0    <= i_funct3;
            addr_p0      <= i_address;
            store_val_p0 <= i_store_val;
        end
        if (i_mem_ack && !is_store_p0) begin
            if (state == ST_BEAT0) rdata0_p1 <= i_mem_val;
            if (state == ST_BEAT1) rdata1_p1 <= i_mem_val;
        end
    end

    always_comb begin
        state_next    = state;
        o_ready       = 1'b0;
        o_done        = 1'b0;
        o_err         = 1'b0;
        o_load_val    = 32'h0;
        o_mem_req     = 1'b0;
        o_mem_op_type = 1'b0;
        o_mem_address = '0;
        o_mem_strobe  = 4'h0;
        o_mem_val     = 32'h0;
        case (state)
            ST_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_next = f3_illegal(i_is_store, i_funct3) ? ST_ERR : ST_BEAT0;
            end
            ST_BEAT0: begin
                o_mem_req     = 1'b1;
                o_mem_op_type = is_store_p0;
                o_mem_address = beat0_addr;
                o_mem_strobe  = lane_mask[3:0];
                o_mem_val     = wdata[31:0];
                if (i_mem_ack) state_next = crosses ? ST_BEAT1 : ST_DONE;
            end
            ST_BEAT1: begin
                o_mem_req     = 1'b1;
                o_mem_op_type = is_store_p0;
                o_mem_address = beat0_addr + ADDR_W'(4);
                o_mem_strobe  = lane_mask[7:4];
                o_mem_val     = wdata[63:32];
                if (i_mem_ack) state_next = ST_DONE;
            end
            ST_DONE: begin
                o_done     = 1'b1;
                o_load_val = is_store_p0 ? 32'h0 : load_ext;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                o_err      = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: aligned/misaligned loads and stores, wrap,
// held acks, illegal codes, ack outside a beat and reset mid-access.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        ready;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_val;
    logic        done;
    logic [31:0] load_val;
    logic        err;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_op_type;
    logic [31:0] mem_address;
    logic [3:0]  mem_strobe;
    logic [31:0] mem_val_out;
    logic [31:0] mem_val_in;

    int tests_run;
    int tests_failed;

    load_store_unit dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_valid       (valid),
        .o_ready       (ready),
        .i_is_store    (is_store),
        .i_funct3      (funct3),
        .i_address     (address),
        .i_store_val   (store_val),
        .o_done        (done),
        .o_load_val    (load_val),
        .o_err         (err),
        .o_mem_req     (mem_req),
        .i_mem_ack     (mem_ack),
        .o_mem_op_type (mem_op_type),
        .o_mem_address (mem_address),
        .o_mem_strobe  (mem_strobe),
        .o_mem_val     (mem_val_out),
        .i_mem_val     (mem_val_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 after the accept edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sv);
        valid = 1'b1; is_store = st; funct3 = f3; address = a; store_val = sv;
        @(negedge clk);
        check_val("ready_before_accept", 32'(ready), 32'h1);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // One memory beat, ack withheld for 'hold' cycles while a stray request is offered.
    task automatic beat(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic exp_op, input logic [31:0] exp_wval,
                        input logic [31:0] rval, input int hold);
        for (int i = 0; i < hold; i++) begin
            valid = 1'b1; funct3 = 3'b010; address = 32'h0000_0F00;
            @(negedge clk);
            check_val({tag, "_hold_req"},   32'(mem_req), 32'h1);
            check_val({tag, "_hold_addr"},  mem_address, exp_addr);
            check_val({tag, "_hold_strb"},  32'(mem_strobe), 32'(exp_strb));
            check_val({tag, "_hold_ready"}, 32'(ready), 32'h0);
            @(posedge clk); #1;
        end
        valid = 1'b0; mem_ack = 1'b1; mem_val_in = rval;
        @(negedge clk);
        check_val({tag, "_req"},  32'(mem_req), 32'h1);
        check_val({tag, "_addr"}, mem_address, exp_addr);
        check_val({tag, "_strb"}, 32'(mem_strobe), 32'(exp_strb));
        check_val({tag, "_op"},   32'(mem_op_type), 32'(exp_op));
        check_val({tag, "_wval"}, mem_val_out, exp_wval);
        check_val({tag, "_done"}, 32'(done), 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_val_in = 32'hA5A5_A5A5;
    endtask

    task automatic finish_access(input string tag, input logic [31:0] exp_load);
        @(negedge clk);
        check_val({tag, "_done"}, 32'(done), 32'h1);
        check_val({tag, "_load"}, load_val, exp_load);
        check_val({tag, "_req"},  32'(mem_req), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val({tag, "_idle_ready"}, 32'(ready), 32'h1);
        check_val({tag, "_idle_done"},  32'(done), 32'h0);
        @(posedge clk); #1;
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst_n = 1'b0; valid = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        address = 32'h0; store_val = 32'h0; mem_ack = 1'b0; mem_val_in = 32'h0;
        #2;
        check_val("rst_ready", 32'(ready), 32'h1);
        check_val("rst_done",  32'(done), 32'h0);
        check_val("rst_err",   32'(err), 32'h0);
        check_val("rst_req",   32'(mem_req), 32'h0);
        check_val("rst_op",    32'(mem_op_type), 32'h0);
        check_val("rst_addr",  mem_address, 32'h0);
        check_val("rst_strb",  32'(mem_strobe), 32'h0);
        check_val("rst_wval",  mem_val_out, 32'h0);
        check_val("rst_load",  load_val, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // LW aligned, immediate ack: done two cycles after accept
        issue(1'b0, 3'b010, 32'h0000_0100, 32'h0);
        beat("lw", 32'h0000_0100, 4'hF, 1'b0, 32'h0, 32'hDEAD_BEEF, 0);
        finish_access("lw", 32'hDEAD_BEEF);

        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        beat("lb", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h8011_2233, 0);
        finish_access("lb", 32'hFFFF_FF80);

        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        beat("lbu", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 32'h8011_2233, 0);
        finish_access("lbu", 32'h0000_0080);

        // SH crossing a word boundary
        issue(1'b1, 3'b001, 32'h0000_00FF, 32'hABCD_1234);
        beat("sh_x0", 32'h0000_00FC, 4'b1000, 1'b1, 32'h3400_0000, 32'h0, 0);
        beat("sh_x1", 32'h0000_0100, 4'b0001, 1'b1, 32'h0000_0012, 32'h0, 0);
        finish_access("sh_x", 32'h0);

        issue(1'b1, 3'b001, 32'h0000_00FE, 32'hABCD_1234);
        beat("sh_hi", 32'h0000_00FC, 4'b1100, 1'b1, 32'h1234_0000, 32'h0, 0);
        finish_access("sh_hi", 32'h0);

        issue(1'b1, 3'b000, 32'h0000_0101, 32'hFFFF_FFA5);
        beat("sb", 32'h0000_0100, 4'b0010, 1'b1, 32'h0000_A500, 32'h0, 0);
        finish_access("sb", 32'h0);

        issue(1'b1, 3'b010, 32'h0000_0200, 32'h0123_4567);
        beat("sw", 32'h0000_0200, 4'hF, 1'b1, 32'h0123_4567, 32'h0, 0);
        finish_access("sw", 32'h0);

        // Misaligned LW wrapping the top of the address space
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0);
        beat("lw_w0", 32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 32'h1122_3344, 0);
        beat("lw_w1", 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h5566_7788, 0);
        finish_access("lw_w", 32'h7788_1122);

        // LH with ack withheld five cycles while a stray request is offered
        issue(1'b0, 3'b001, 32'h0000_0202, 32'h0);
        beat("lh_hold", 32'h0000_0200, 4'b1100, 1'b0, 32'h0, 32'hBEEF_0000, 5);
        finish_access("lh_hold", 32'hFFFF_BEEF);

        issue(1'b0, 3'b101, 32'h0000_0202, 32'h0);
        beat("lhu", 32'h0000_0200, 4'b1100, 1'b0, 32'h0, 32'hBEEF_0000, 0);
        finish_access("lhu", 32'h0000_BEEF);

        // Illegal load code
        issue(1'b0, 3'b011, 32'h0000_0100, 32'h0);
        @(negedge clk);
        check_val("err_pulse", 32'(err), 32'h1);
        check_val("err_req",   32'(mem_req), 32'h0);
        check_val("err_done",  32'(done), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("err_clear", 32'(err), 32'h0);
        check_val("err_req2",  32'(mem_req), 32'h0);
        check_val("err_ready", 32'(ready), 32'h1);
        @(posedge clk); #1;

        // Illegal store code (unsigned store)
        issue(1'b1, 3'b100, 32'h0000_0100, 32'h0);
        @(negedge clk);
        check_val("serr_pulse", 32'(err), 32'h1);
        check_val("serr_req",   32'(mem_req), 32'h0);
        @(posedge clk); #1;

        // Ack while idle is ignored
        mem_ack = 1'b1;
        @(negedge clk);
        check_val("idle_ack_req",  32'(mem_req), 32'h0);
        check_val("idle_ack_done", 32'(done), 32'h0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        check_val("idle_ack_done2", 32'(done), 32'h0);
        check_val("idle_ack_ready", 32'(ready), 32'h1);
        @(posedge clk); #1;

        // Reset asserted during the second beat of a misaligned load
        issue(1'b0, 3'b010, 32'h0000_00FD, 32'h0);
        beat("rst_b0", 32'h0000_00FC, 4'b1110, 1'b0, 32'h0, 32'h0, 0);
        @(negedge clk);
        check_val("rst_b1_req",  32'(mem_req), 32'h1);
        check_val("rst_b1_addr", mem_address, 32'h0000_0100);
        check_val("rst_b1_strb", 32'(mem_strobe), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid_req",   32'(mem_req), 32'h0);
        check_val("rst_mid_addr",  mem_address, 32'h0);
        check_val("rst_mid_strb",  32'(mem_strobe), 32'h0);
        check_val("rst_mid_ready", 32'(ready), 32'h1);
        check_val("rst_mid_done",  32'(done), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("rst_after_done", 32'(done), 32'h0);
            check_val("rst_after_req",  32'(mem_req), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
